ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
Synchronous first-word-fall-through FIFO controller that sequences one dual_port_ram instance (1 write port, 1 registered read port, 1-cycle read latency, old-data on read-during-write).
Presents valid/ready streams on both sides, hides the RAM read latency by prefetching the next head, and reports occupancy.
Used as the buffering element between MCU peripherals (UART/debug streams) and the core bus.

Parameters:
ADDR_WIDTH, 5, RAM address width; DEPTH = 2**ADDR_WIDTH entries (localparam)
DATA_WIDTH, 32, word width
AFULL_LEVEL, 2**ADDR_WIDTH - 2, occupancy at or above which almost_full asserts

Ports:
clk  in  1  single clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear; dominates push/pop in the same cycle
wr_data  in  DATA_WIDTH  push data
wr_valid  in  1  push request
wr_ready  out  1  FIFO can accept (= !full)
rd_data  out  DATA_WIDTH  head word; RAM dout, not reset, meaningful only when rd_valid=1
rd_valid  out  1  head word present on rd_data
rd_ready  in  1  consumer accepts head
count  out  ADDR_WIDTH+1  total entries, including writes not yet visible
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_LEVEL

Behaviour:
- Reset (async, reset_n=0): wptr=0, rptr=0, count=0, vis_count=0, wr_d1=0, so rd_valid=0, wr_ready=1, full=0, empty=1, almost_full=0 (when AFULL_LEVEL>0).
- push = wr_valid & wr_ready; pop = rd_valid & rd_ready.
- RAM hookup: waddr=wptr[ADDR_WIDTH-1:0], din=wr_data, write_en=push, raddr = pop ? rptr+1 : rptr (mod DEPTH), rd_data=dout.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- count_next = count + push - pop. wr_d1 <= push.
- Visibility counter: vis_count_next = vis_count + wr_d1 - pop; rd_valid = (vis_count != 0).
- Latency: push accepted in cycle t -> RAM write at edge t+1 -> rd_valid and data at cycle t+2 when the FIFO was empty. Pop in cycle t -> next head valid at t+1 if already visible.
- Read-during-write to raddr returns old data; the vis_count lag guarantees such a word is never flagged valid. rd_data stays stable while rd_valid=1 and rd_ready=0, because raddr holds and the head slot cannot be written.
- Full: wr_ready=0; wr_valid is ignored with no pointer or count change; a same-cycle pop does not enable a push (ready is registered-state based, not pop-dependent).
- Empty: rd_valid=0; rd_ready is ignored.
- Simultaneous push and pop (not full, head visible): count unchanged, both pointers advance.
- flush=1: next edge sets wptr=rptr=0, count=vis_count=0, wr_d1=0; any push/pop that cycle is discarded.
- Reset asserted mid-operation: immediate return to reset state; contents are discarded (RAM is not cleared).
- Invariants: vis_count <= count <= DEPTH; count - vis_count <= 1.

Decomposition:
- No shared package typedefs are required; DEPTH and the pointer/count widths are localparams derived from ADDR_WIDTH.
- One sub-module: the existing dual_port_ram, instantiated with ADDR_WIDTH and DATA_WIDTH; all control stays in ram_fifo_ctrl.

Test Plan:
(ADDR_WIDTH=2, DEPTH=4, AFULL_LEVEL=2, DATA_WIDTH=32)
- Reset then single push 0xA5A5_0001 at cycle 0 -> rd_valid=0 at cycles 0 and 1, rd_valid=1 with rd_data=0xA5A5_0001 at cycle 2; count=1 from cycle 1.
- Push 0x1,0x2,0x3,0x4 back-to-back with rd_ready=0 -> full=1, wr_ready=0, count=4, almost_full=1 from count=2; fifth push 0x5 is dropped; drain yields 0x1..0x4 in order, then empty=1.
- Continuous push and pop with rd_ready=1 for 10 words 0x10..0x19 -> output order 0x10..0x19 across pointer wrap, no duplicate or lost word, count never exceeds 2.
- Back-pressure: 3 words queued, rd_ready toggled 0/1 each cycle -> rd_data constant while stalled, words delivered in order.
- Simultaneous push and pop at count=2 -> count stays 2, head advances to next word one cycle later.
- flush with count=3 plus concurrent push -> next cycle count=0, empty=1, rd_valid=0; a later push of 0x77 appears at rd_data 2 cycles after acceptance. Repeat with reset_n pulsed low mid-stream -> same clean state asynchronously.

Source files
------------

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults for the RAM-backed FWFT FIFO controller.
package ram_fifo_ctrl_pkg;

    // Default geometry: 32 entries of 32-bit words.
    localparam int RFC_ADDR_WIDTH = 5;
    localparam int RFC_DATA_WIDTH = 32;

    // The head word becomes visible this many cycles after its push is accepted
    // (one edge to write the RAM, one edge to read it back).
    localparam int RFC_VIS_LATENCY = 2;

endpackage

// File: rtl/ram_fifo_ctrl_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module dual_port_ram
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RFC_ADDR_WIDTH,
    parameter int DATA_WIDTH = RFC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // Write and registered read share one edge, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[waddr] <= din;
        end
        dout_q <= mem_q[raddr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a dual_port_ram.
// count tracks every accepted word; vis_count lags it by one write so that
// rd_valid only rises once the head word has actually been read out of the RAM.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = RFC_ADDR_WIDTH,
    parameter int DATA_WIDTH  = RFC_DATA_WIDTH,
    parameter int AFULL_LEVEL = 2 ** ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // One extra bit so an out-of-range level cannot alias onto a small count.
    localparam logic [CW:0]   AFULL_C = (CW + 1)'(AFULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         vis_q, vis_d;
    logic                  wr_d1_q, wr_d1_d;

    logic                  push;
    logic                  pop;
    logic                  push_en;
    logic                  pop_en;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] ram_dout;

    // Status flags come straight from registered state; wr_ready never depends on pop.
    always_comb begin
        full        = (count_q == DEPTH_C);
        empty       = (count_q == '0);
        almost_full = ({1'b0, count_q} >= AFULL_C);
        wr_ready    = ~full;
        rd_valid    = (vis_q != '0);
        count       = count_q;
        rd_data     = ram_dout;
    end

    // Handshakes and RAM read address; reading rptr+1 on a pop prefetches the next head.
    always_comb begin
        push    = wr_valid & wr_ready;
        pop     = rd_valid & rd_ready;
        push_en = push & ~flush;
        pop_en  = pop & ~flush;
        raddr   = pop ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    end

    // Next-state for pointers and counters; flush wins over any same-cycle transfer.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        vis_d   = vis_q;
        wr_d1_d = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            vis_d   = '0;
            wr_d1_d = 1'b0;
        end else begin
            wr_d1_d = push_en;
            if (push_en) begin
                wptr_d = wptr_q + ADDR_WIDTH'(1);
            end
            if (pop_en) begin
                rptr_d = rptr_q + ADDR_WIDTH'(1);
            end
            count_d = count_q + CW'(push_en) - CW'(pop_en);
            // A word written at the last edge is readable at the next one.
            vis_d   = vis_q + CW'(wr_d1_q) - CW'(pop_en);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            vis_q   <= '0;
            wr_d1_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            vis_q   <= vis_d;
            wr_d1_q <= wr_d1_d;
        end
    end

    dual_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk      (clk),
        .write_en (push_en),
        .waddr    (wptr_q),
        .din      (wr_data),
        .raddr    (raddr),
        .dout     (ram_dout)
    );

endmodule
